// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared FSM state type, ack spacing constant and pointer-width helper.
// Used by: counter_sched (top) and rr_pick (round-robin picker).
package counter_sched_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;
  localparam int MIN_ACK_SPACING = 2;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: i_req  - request vector
//        i_mask - requesters excluded this cycle
//        i_ptr  - highest-priority index
//        o_valid - any unmasked request present
//        o_idx   - first unmasked request at or above i_ptr, wrapping
module rr_pick
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [PW-1:0]   o_idx
);
  logic [NREQ-1:0] w_req;
  assign w_req   = i_req & ~i_mask;
  assign o_valid = |w_req;
  // Lowest set bit is the wrap-around fallback; a set bit at/above the pointer overrides it.
  always_comb begin
    o_idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) if (w_req[j]) o_idx = PW'(j);
    for (int j = NREQ - 1; j >= 0; j--) if (w_req[j] && j >= int'(i_ptr)) o_idx = PW'(j);
  end
endmodule

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one accumulating counter among NREQ requesters.
// Ports: i_clk, i_rst_n (async active-low), i_clr (sync clear of count, aborts grant),
//        i_req[NREQ] request levels, i_step[NREQ*WIDTH] per-requester add values,
//        o_ack[NREQ] one-hot applied pulse, o_count accumulated value,
//        o_ovf carry (or clamp) pulse with ack, o_busy state != IDLE.
// Build option: COUNTER_SCHED_SAT_EN saturates the add at all-ones instead of wrapping.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int GAP   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_step,
  output logic [NREQ-1:0]       o_ack,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_ovf,
  output logic                  o_busy
);
  localparam int PW = ptr_w(NREQ);
  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, r_win, w_idx;
  logic [WIDTH-1:0] r_count, r_step, w_sel_step, w_new;
  logic [WIDTH:0]   w_sum;
  logic [NREQ-1:0]  r_ack;
  logic [7:0]       r_gap;
  logic             r_ovf, r_busy, w_valid;

  // The requester being acked this cycle is masked so a late req drop cannot re-win.
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req  (i_req),
    .i_mask (r_ack),
    .i_ptr  (r_ptr),
    .o_valid(w_valid),
    .o_idx  (w_idx)
  );

  always_comb begin
    w_sel_step = '0;
    for (int j = 0; j < NREQ; j++) if (w_idx == PW'(j)) w_sel_step = i_step[j*WIDTH +: WIDTH];
  end

  assign w_sum = {1'b0, r_count} + {1'b0, r_step};
`ifdef COUNTER_SCHED_SAT_EN
  assign w_new = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
  assign w_new = w_sum[WIDTH-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = i_clr              ? IDLE :
                  (r_state == IDLE)  ? (w_valid ? APPLY : IDLE) :
                  (r_state == APPLY) ? ((GAP > 0) ? HOLD : IDLE) :
                  (r_gap == 8'd1)    ? IDLE : HOLD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ack   <= '0;
      r_ovf   <= 1'b0;
      r_ptr   <= '0;
      r_gap   <= '0;
      r_win   <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_state_nxt != IDLE;
      r_ack   <= '0;
      r_ovf   <= 1'b0;
      if (i_clr) begin
        r_count <= '0;
        r_gap   <= '0;
      end else if (r_state == IDLE && w_valid) begin
        r_win  <= w_idx;
        r_step <= w_sel_step;
      end else if (r_state == APPLY) begin
        r_count <= w_new;
        r_ack   <= NREQ'(1) << r_win;
        r_ovf   <= w_sum[WIDTH];
        r_ptr   <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        r_gap   <= 8'(GAP);
      end else if (r_state == HOLD) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
  assign o_busy  = r_busy;
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: scoreboard bench running GAP=0 and GAP=2 instances against a cycle-level reference model.
module tb_counter_sched;
  import counter_sched_pkg::*;
  localparam int W = 8;
  localparam int N = 4;
  typedef struct {int due; int win; int cnt; bit ovf;} exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit done[2];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  genvar g;
  for (g = 0; g < 2; g++) begin : inst
    localparam int G = 2 * g;
    logic rst_n = 0;
    logic clr = 0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] step = '0;
    logic [N-1:0] ack;
    logic [W-1:0] count;
    logic ovf, busy;

    counter_sched #(.WIDTH(W), .NREQ(N), .GAP(G)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_req(req), .i_step(step),
      .o_ack(ack), .o_count(count), .o_ovf(ovf), .o_busy(busy)
    );

    exp_t q[$];
    int t = 0, nf = 0, ptr = 0, mcount = 0, gw = 0, gt = 0, gcnt = 0, ack_win = -1, just = -1;
    int late_mode = 0;
    bit inflight = 0;
    bit drop_next[N];

    task automatic m_reset();
      q.delete();
      nf = 0; ptr = 0; mcount = 0; inflight = 0; ack_win = -1; just = -1;
    endtask

    // One clock edge of the reference: arbitration window, apply, clear, abort.
    task automatic m_edge();
      logic [N-1:0] eff;
      int sum;
      exp_t e;
      t++;
      just = -1;
      if (!rst_n) begin
        m_reset();
        return;
      end
      eff = req & ~((ack_win >= 0) ? (N'(1) << ack_win) : N'(0));
      ack_win = -1;
      if (clr) begin
        mcount = 0;
        if (inflight && q.size() > 0 && q[$].due == t) void'(q.pop_back());
        inflight = 0;
        nf = t + 1;
      end else if (inflight && t == gt + 1) begin
        mcount = gcnt;
        ptr = (gw + 1) % N;
        ack_win = gw;
        inflight = 0;
      end else if (t >= nf && eff != 0) begin
        for (int k = 0; k < N; k++) if (eff[(ptr + k) % N]) begin gw = (ptr + k) % N; break; end
        sum = mcount + int'(step[gw*W +: W]);
        e.due = t + 1;
        e.win = gw;
        e.ovf = sum >= 2**W;
`ifdef COUNTER_SCHED_SAT_EN
        e.cnt = e.ovf ? 2**W - 1 : sum;
`else
        e.cnt = sum % (2**W);
`endif
        gcnt = e.cnt;
        q.push_back(e);
        inflight = 1;
        gt = t;
        nf = t + MIN_ACK_SPACING + G;
        just = gw;
      end
    endtask

    initial forever begin
      exp_t e;
      @(negedge clk);
      if (ack != 0) begin
        if (q.size() == 0) check($sformatf("g%0d unexpected_ack", G), int'(ack), 0);
        else begin
          e = q.pop_front();
          check($sformatf("g%0d ack_onehot", G), int'(ack), 1 << e.win);
          check($sformatf("g%0d ack_time", G), t, e.due);
          check($sformatf("g%0d ack_count", G), int'(count), e.cnt);
          check($sformatf("g%0d ack_ovf", G), int'(ovf), int'(e.ovf));
        end
      end else begin
        if (q.size() > 0 && q[0].due <= t) begin
          check($sformatf("g%0d missing_ack", G), int'(ack), 1 << q[0].win);
          void'(q.pop_front());
        end
        check($sformatf("g%0d ovf_idle", G), int'(ovf), 0);
      end
      check($sformatf("g%0d count", G), int'(count), mcount);
      check($sformatf("g%0d busy", G), int'(busy), int'(t < nf - 1));
    end

    task automatic tick();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (drop_next[i]) begin req[i] = 1'b0; drop_next[i] = 0; end
        if (ack[i]) begin
          if (late_mode == 1 || (late_mode == 2 && $urandom_range(1, 0) == 1)) drop_next[i] = 1;
          else req[i] = 1'b0;
        end
      end
    endtask

    task automatic ask(input int i, input int s);
      req[i] = 1'b1;
      step[i*W +: W] = W'(s);
    endtask

    task automatic wait_ack(input int i, input string nm);
      for (int k = 0; k < 40 && !ack[i]; k++) tick();
      check($sformatf("g%0d %s", G, nm), int'(ack[i]), 1);
    endtask

    task automatic wait_grant();
      for (int k = 0; k < 40 && just < 0; k++) tick();
      check($sformatf("g%0d grant_busy", G), int'(busy), 1);
    endtask

    task automatic drain();
      for (int k = 0; k < 300 && (req != 0 || busy); k++) tick();
      tick();
      check($sformatf("g%0d drain_idle", G), int'(busy), 0);
    endtask

    initial begin
      int c0;
      tick();
      tick();
      check($sformatf("g%0d rst_count", G), int'(count), 0);
      check($sformatf("g%0d rst_ack", G), int'(ack), 0);
      check($sformatf("g%0d rst_busy", G), int'(busy), 0);
      rst_n = 1;
      tick();
      late_mode = 1;
      ask(1, 5);
      wait_ack(1, "single_ack");
      check($sformatf("g%0d single_vec", G), int'(ack), 2);
      check($sformatf("g%0d single_count", G), int'(count), 5);
      check($sformatf("g%0d single_ovf", G), int'(ovf), 0);
      for (int k = 0; k < 4; k++) tick();
      late_mode = 0;
      for (int c = 0; c < 16 * (2 + G); c++) begin
        for (int i = 0; i < N; i++) if (!req[i]) ask(i, 1);
        tick();
      end
      drain();
      clr = 1;
      tick();
      clr = 0;
      ask(2, 250);
      wait_ack(2, "ovf_first");
      ask(3, 10);
      wait_ack(3, "ovf_second");
`ifdef COUNTER_SCHED_SAT_EN
      c0 = 255;
`else
      c0 = 4;
`endif
      check($sformatf("g%0d ovf_count", G), int'(count), c0);
      check($sformatf("g%0d ovf_flag", G), int'(ovf), 1);
      ask(0, 0);
      wait_ack(0, "zero_ack");
      check($sformatf("g%0d zero_count", G), int'(count), c0);
      check($sformatf("g%0d zero_ovf", G), int'(ovf), 0);
      drain();
      ask(1, 7);
      wait_grant();
      clr = 1;
      tick();
      clr = 0;
      check($sformatf("g%0d clr_count", G), int'(count), 0);
      check($sformatf("g%0d clr_ack", G), int'(ack), 0);
      check($sformatf("g%0d clr_busy", G), int'(busy), 0);
      ask(2, 3);
      drain();
      late_mode = 2;
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(3, 0) == 0) ask(i, $urandom_range(255, 0));
        if (just >= 0 && $urandom_range(1, 0) == 1) step[just*W +: W] = W'($urandom);
        clr = ($urandom_range(39, 0) == 0);
        tick();
      end
      clr = 0;
      late_mode = 0;
      drain();
      for (int i = 0; i < N; i++) ask(i, i + 1);
      wait_grant();
      rst_n = 0;
      #1;
      check($sformatf("g%0d midrst_count", G), int'(count), 0);
      check($sformatf("g%0d midrst_ack", G), int'(ack), 0);
      check($sformatf("g%0d midrst_busy", G), int'(busy), 0);
      m_reset();
      tick();
      tick();
      rst_n = 1;
      for (int k = 0; k < 40 && ack == 0; k++) tick();
      check($sformatf("g%0d post_rst_first", G), int'(ack), 1);
      drain();
      done[g] = 1;
    end
  end

  initial begin
    for (int k = 0; k < 30000 && !(done[0] && done[1]); k++) @(posedge clk);
    if (!(done[0] && done[1])) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: done flags %0d%0d expected 11", done[0], done[1]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares a single WIDTH-bit accumulating counter among NREQ requesters.
- Each requester asks for "add step_i to count" via a req/ack handshake.
- The block arbitrates, applies exactly one add per grant, and enforces an optional idle gap between adds.
- Sits between requester logic and the counter datapath; owns the count register.

Parameters:
- WIDTH, 8, count and step width.
- NREQ, 4, number of requesters (2..16).
- GAP, 0, idle cycles inserted after each applied add (0..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserts on rst=0, independent of clk).
- clr  input  1  synchronous clear of count; highest priority after reset.
- req  input  NREQ  per-requester request level.
- step  input  NREQ*WIDTH  add value; requester i uses bits [i*WIDTH +: WIDTH].
- ack  output  NREQ  one-hot, one-cycle pulse: add for requester i applied.
- count  output  WIDTH  current accumulated value.
- ovf  output  1  one-cycle pulse with ack when the add carried out of WIDTH bits.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0): state=IDLE, count=0, ack=0, ovf=0, rr pointer=0, gap counter=0. All outputs are registered.
- States: IDLE, APPLY, HOLD.
- IDLE:
  - If any unmasked req is high, pick the winner by round-robin: first set bit at or above the pointer, wrapping.
  - Latch the winner index and its step at this edge; go to APPLY.
  - Otherwise stay in IDLE.
- APPLY (exactly one cycle):
  - At the exit edge: count <= count + latched step; ack[winner] <= 1; ovf <= carry; pointer <= winner+1 mod NREQ.
  - Next state is HOLD if GAP>0, else IDLE.
- HOLD:
  - Load gap counter with GAP on entry; decrement each cycle.
  - Return to IDLE on the edge where the counter reaches 1.
  - req is ignored while in HOLD.
- Latency: req sampled at edge E0 -> ack and new count visible together after E1. Minimum ack spacing is 2+GAP cycles.
- Handshake:
  - Requester holds req and step stable until ack is seen, then drops req.
  - In the cycle ack[i] is high, req[i] is masked from arbitration, so no double grant occurs if req drops one cycle late.
  - step changes after the grant edge have no effect.
- Arithmetic: unsigned, modulo 2^WIDTH (see Optional Feature). step=0 is legal: ack pulses, count is unchanged, ovf=0.
- clr:
  - In any state: count <= 0, state <= IDLE, in-flight grant is aborted (no ack, no ovf), pointer is retained.
  - clr and an APPLY exit in the same cycle: clr wins and no ack is produced.
- Reset mid-operation: immediate return to reset values; no ack is emitted.
- ack and ovf are 0 on every cycle other than the one after APPLY.

Optional Feature:
- Macro COUNTER_SCHED_SAT_EN.
- Defined: the add saturates at all-ones (2^WIDTH-1); ovf pulses whenever clamping occurred.
- Undefined: the add wraps modulo 2^WIDTH; ovf pulses on carry-out.
- Handshake timing is identical in both builds.

Decomposition:
- Package counter_sched_pkg:
  - state_t enum {IDLE, APPLY, HOLD}.
  - Constant for minimum ack spacing (2).
  - Function clog2-based pointer width helper.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, mask, pointer.
  - Outputs: valid and winner index.
  - Instantiated once.

Test Plan:
- Reset: run with req=4'b1111, drive rst=0 mid-APPLY -> count=0, ack=0, busy=0 immediately; after release, first grant goes to requester 0.
- Single requester: count=0, req[1]=1, step1=5, GAP=0 -> ack=4'b0010 one cycle after APPLY, count=5, ovf=0, exactly one ack while req is held one extra cycle.
- Contention: req=4'b1111, all steps=1, GAP=0 -> ack order 0,1,2,3,0,... every 2 cycles, count increments by 1 per ack.
- Overflow: WIDTH=8, count=250, step=10 -> wrap build count=4, ovf=1; SAT_EN build count=255, ovf=1. Then step=0 -> ack, ovf=0.
- clr collision: assert clr in the APPLY cycle with step=7 -> no ack, count=0, state IDLE; next grant goes to the next requester in rotation after the aborted winner's predecessor (pointer unchanged).
- Gap: GAP=2, req=4'b0011 held -> acks exactly 4 cycles apart, busy high throughout HOLD, req ignored during HOLD.
